// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
//   Shared definitions for the load/store unit: access size encodings,
//   response error codes, the FSM state type, the default memory timeout and
//   a helper that classifies a request as legal, misaligned or illegal-size.
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

    // req_size encodings
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    // resp_err codes
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILL_SIZE = 2'b11;

    // Cycles spent in ACCESS waiting for mem_ack before the access is abandoned
    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // Classify a request before it reaches memory. An illegal size outranks
    // misalignment, so it is tested first.
    function automatic logic [1:0] lsu_req_err(input logic [1:0] size,
                                               input logic [1:0] offset);
        logic [1:0] err;
        err = ERR_OK;
        if (size == SIZE_ILL) begin
            err = ERR_ILL_SIZE;
        end else if (size == SIZE_HALF && offset[0]) begin
            err = ERR_MISALIGN;
        end else if (size == SIZE_WORD && offset != 2'b00) begin
            err = ERR_MISALIGN;
        end
        return err;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
//   Purely combinational big-endian lane logic for the load/store unit.
//   Byte offset k lives in bits [31-8k:24-8k] and is enabled by mem_be[3-k].
//
//   Store side (placement):
//     st_size, st_offset   access size and byte offset of the store
//     st_wdata             right-justified store data
//     st_be                byte enables for the addressed lanes
//     st_data              store data replicated across all lanes
//   Load side (extraction):
//     ld_size, ld_offset   access size and byte offset of the load
//     ld_unsigned          1 = zero-extend, 0 = sign-extend (ignored for words)
//     ld_rdata             word returned by memory
//     ld_data              addressed lane, extended to 32 bits
// -----------------------------------------------------------------------------
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_offset,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Replicating the data means the memory only needs mem_be to pick lanes;
    // no shifter is required on the write path.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        st_be   = 4'b0000;
        st_data = st_wdata;
        case (st_size)
            SIZE_BYTE: begin
                st_be   = 4'b1000 >> st_offset;
                st_data = {4{st_wdata[7:0]}};
            end
            SIZE_HALF: begin
                st_be   = st_offset[1] ? 4'b0011 : 4'b1100;
                st_data = {2{st_wdata[15:0]}};
            end
            SIZE_WORD: begin
                st_be   = 4'b1111;
            end
            default: begin
                st_be   = 4'b0000;
            end
        endcase
    end

    always_comb begin
        ld_byte = 8'h00;
        case (ld_offset)
            2'd0:    ld_byte = ld_rdata[31:24];
            2'd1:    ld_byte = ld_rdata[23:16];
            2'd2:    ld_byte = ld_rdata[15:8];
            default: ld_byte = ld_rdata[7:0];
        endcase
        ld_half = ld_offset[1] ? ld_rdata[15:0] : ld_rdata[31:16];

        ld_data = 32'h0;
        case (ld_size)
            SIZE_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            SIZE_WORD: ld_data = ld_rdata;
            default:   ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Single-outstanding big-endian load/store unit. Accepts one request in IDLE,
//   performs a single word access to data memory in ACCESS, and returns a
//   one-cycle response in RESP. Misaligned or illegal-size requests skip
//   memory entirely; an access that sees no mem_ack for TIMEOUT_CYCLES cycles
//   is abandoned with a timeout error. Every output is a flop.
//
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     req_*             request handshake and fields (valid/ready)
//     resp_valid        one-cycle response strobe
//     resp_rdata        extended load data (0 for stores and errors)
//     resp_err          00 ok, 01 misaligned, 10 timeout, 11 illegal size
//     mem_addr          word-aligned address to data memory
//     mem_wdata, mem_be lane-placed store data and byte enables
//     mem_lw_en/sw_en   load / store strobes, held for the whole access
//     mem_rdata, mem_ack  memory read data and completion
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_lw_en,
    output logic        mem_sw_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [1:0]        resp_err_q, resp_err_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              mem_lw_en_q, mem_lw_en_d;
    logic              mem_sw_en_q, mem_sw_en_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Request fields latched at acceptance, needed later to extract load data
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        offset_q, offset_d;
    logic              unsigned_q, unsigned_d;

    logic [3:0]        place_be;
    logic [31:0]       place_data;
    logic [31:0]       load_data;
    logic [1:0]        req_err;

    // Placement works on the live request (it is registered at acceptance);
    // extraction works on the latched fields against the returning word.
    lsu_lane_align u_lane_align (
        .st_size     (req_size),
        .st_offset   (req_addr[1:0]),
        .st_wdata    (req_wdata),
        .st_be       (place_be),
        .st_data     (place_data),
        .ld_size     (size_q),
        .ld_offset   (offset_q),
        .ld_unsigned (unsigned_q),
        .ld_rdata    (mem_rdata),
        .ld_data     (load_data)
    );

    assign req_err = lsu_req_err(req_size, req_addr[1:0]);

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        mem_lw_en_d  = mem_lw_en_q;
        mem_sw_en_d  = mem_sw_en_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        offset_d     = offset_q;
        unsigned_d   = unsigned_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    size_d      = req_size;
                    offset_d    = req_addr[1:0];
                    unsigned_d  = req_unsigned;
                    req_ready_d = 1'b0;
                    if (req_err != ERR_OK) begin
                        // Rejected requests never touch memory
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = req_err;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = place_data;
                        mem_be_d    = place_be;
                        mem_lw_en_d = ~req_we;
                        mem_sw_en_d = req_we;
                        cnt_d       = '0;
                    end
                end
            end

            ST_ACCESS: begin
                // mem_ack is tested first so an ack on the final cycle wins
                if (mem_ack) begin
                    state_d      = ST_RESP;
                    mem_lw_en_d  = 1'b0;
                    mem_sw_en_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_OK;
                    resp_rdata_d = we_q ? 32'h0 : load_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = ST_RESP;
                    mem_lw_en_d  = 1'b0;
                    mem_sw_en_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_TIMEOUT;
                    resp_rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state is only ever written with <= so every flop samples the pre-edge value of every other flop.
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= ERR_OK;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_be_q     <= 4'b0000;
            mem_lw_en_q  <= 1'b0;
            mem_sw_en_q  <= 1'b0;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            size_q       <= SIZE_BYTE;
            offset_q     <= 2'b00;
            unsigned_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            mem_lw_en_q  <= mem_lw_en_d;
            mem_sw_en_q  <= mem_sw_en_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            offset_q     <= offset_d;
            unsigned_q   <= unsigned_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign mem_lw_en  = mem_lw_en_q;
    assign mem_sw_en  = mem_sw_en_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Scoreboard bench for load_store_unit. Inputs are driven on the falling
//   edge; outputs are observed 1 ns after the rising edge. Each issued request
//   pushes an expected memory access and an expected response (value, error
//   and arrival cycle) computed by an arithmetic big-endian model. A monitor
//   process acts as the data memory, checks the access and returns mem_ack
//   after the chosen delay, and pops/compares responses as they appear.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_lw_en;
    logic        mem_sw_en;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_lw_en    (mem_lw_en),
        .mem_sw_en    (mem_sw_en),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        int          delay;
        logic [31:0] rdata;
    } mem_t;

    resp_t sq[$];
    mem_t  mq[$];

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    logic stray_ack   = 1'b0;

    // memory-responder state, owned by the monitor process
    logic mon_active = 1'b0;
    mem_t mon_cur;
    int   mon_count  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event seen where none was expected (cycle %0d)", name, cyc);
    endtask

    // Big-endian reference: byte k of a word is the k-th byte from the MSB.
    function automatic void model(
        input  logic        we,
        input  logic [1:0]  size,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic        uns,
        input  int          delay,
        input  logic [31:0] rdata,
        output logic [1:0]  err,
        output logic [3:0]  be,
        output logic [31:0] wd,
        output logic [31:0] rd,
        output int          lat
    );
        int          off;
        int          nbytes;
        int          shift;
        logic [31:0] mask;
        logic [31:0] val;
        off    = int'(addr % 32'd4);
        nbytes = 1 << int'(size);
        be     = 4'b0000;
        wd     = 32'h0;
        rd     = 32'h0;
        lat    = 0;
        if (size == 2'b11)            err = 2'b11;
        else if (off % nbytes != 0)   err = 2'b01;
        else                          err = 2'b00;
        if (err != 2'b00) return;
        for (int k = off; k < off + nbytes; k++) be[3 - k] = 1'b1;
        if (nbytes == 1)      wd = (wdata & 32'hFF)   * 32'h0101_0101;
        else if (nbytes == 2) wd = (wdata & 32'hFFFF) * 32'h0001_0001;
        else                  wd = wdata;
        shift = 8 * (4 - off - nbytes);
        mask  = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        val   = (rdata >> shift) & mask;
        if (!uns && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
        rd = we ? 32'h0 : val;
        if (delay > T) begin
            err = 2'b10;
            rd  = 32'h0;
            lat = T;
        end else begin
            lat = delay;
        end
    endfunction

    task automatic drive_junk();
        req_valid    = 1'($urandom);
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic uns, input int delay,
                         input logic [31:0] rdata);
        resp_t       r;
        mem_t        m;
        logic [1:0]  err;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        int          lat;
        int          guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            drive_junk();
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            fail("req_ready_wait_expired");
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        model(we, size, addr, wdata, uns, delay, rdata, err, be, wd, rd, lat);
        if (err == 2'b00 || err == 2'b10) begin
            m.addr  = addr & ~32'd3;
            m.be    = be;
            m.wdata = wd;
            m.we    = we;
            m.delay = delay;
            m.rdata = rdata;
            mq.push_back(m);
        end
        // accepted at the coming rising edge (cyc + 1); response visible lat cycles later
        r.rdata = rd;
        r.err   = err;
        r.cyc   = cyc + 1 + lat;
        sq.push_back(r);
        @(negedge clk);
        // the unit is busy now: anything presented must be ignored
        drive_junk();
    endtask

    // Monitor: plays data memory and checks responses
    always @(posedge clk) begin
        cyc++;
        #1;
        mem_ack   = stray_ack;
        mem_rdata = $urandom;
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (mem_lw_en && mem_sw_en) fail("both_enables");
            if (mem_lw_en || mem_sw_en) begin
                if (!mon_active) begin
                    if (mq.size() == 0) begin
                        fail("unexpected_mem_enable");
                    end else begin
                        mon_cur    = mq.pop_front();
                        mon_active = 1'b1;
                        mon_count  = 0;
                    end
                end
                if (mon_active) begin
                    mon_count++;
                    check("mem_addr",  mem_addr,  mon_cur.addr);
                    check("mem_be",    32'(mem_be),    32'(mon_cur.be));
                    check("mem_wdata", mon_cur.we ? mem_wdata : 32'h0, mon_cur.we ? mon_cur.wdata : 32'h0);
                    check("mem_lw_en", 32'(mem_lw_en), mon_cur.we ? 32'd0 : 32'd1);
                    check("mem_sw_en", 32'(mem_sw_en), mon_cur.we ? 32'd1 : 32'd0);
                    if (mon_count == mon_cur.delay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mon_cur.rdata;
                    end
                end
            end else if (mon_active) begin
                check("access_cycles", 32'(mon_count), 32'((mon_cur.delay > T) ? T : mon_cur.delay));
                mon_active = 1'b0;
            end
            if (resp_valid) begin
                if (sq.size() == 0) begin
                    fail("unexpected_resp_valid");
                end else begin
                    resp_t e;
                    e = sq.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err",   32'(resp_err), 32'(e.err));
                    check("resp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"},  32'(req_ready),  32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_mem_lw_en"},  32'(mem_lw_en),  32'd0);
        check({tag, "_mem_sw_en"},  32'(mem_sw_en),  32'd0);
        check({tag, "_mem_be"},     32'(mem_be),     32'd0);
        check({tag, "_mem_addr"},   mem_addr,        32'd0);
        check({tag, "_mem_wdata"},  mem_wdata,       32'd0);
        check({tag, "_resp_rdata"}, resp_rdata,      32'd0);
        check({tag, "_resp_err"},   32'(resp_err),   32'd0);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          r;
        int          guard;
        logic [1:0]  sz;
        logic [31:0] addr;
        int          dly;

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        idle(1);

        // Directed cases
        issue(1'b1, 2'b10, 32'h40, 32'h1122_3344, 1'b0, 1, $urandom);   // store word
        issue(1'b0, 2'b00, 32'h43, 32'h0, 1'b0, 2, 32'h0000_00F0);      // signed byte load
        issue(1'b0, 2'b00, 32'h43, 32'h0, 1'b1, 1, 32'h0000_00F0);      // unsigned byte load
        issue(1'b1, 2'b01, 32'h42, 32'h0000_ABCD, 1'b0, 3, $urandom);   // store half
        issue(1'b0, 2'b01, 32'h40, 32'h0, 1'b0, 1, 32'h8001_5A5A);      // signed half load
        issue(1'b0, 2'b10, 32'h41, 32'h0, 1'b0, 1, $urandom);           // misaligned word
        issue(1'b0, 2'b01, 32'h43, 32'h0, 1'b0, 1, $urandom);           // misaligned half
        issue(1'b1, 2'b11, 32'h41, 32'h0, 1'b0, 1, $urandom);           // illegal size wins
        issue(1'b0, 2'b10, 32'h40, 32'h0, 1'b0, T + 1, $urandom);       // timeout
        issue(1'b0, 2'b10, 32'h40, 32'h0, 1'b0, T, 32'hCAFE_F00D);      // ack on last cycle
        issue(1'b1, 2'b00, 32'h45, 32'h0000_0077, 1'b0, T + 4, $urandom); // store timeout
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            r  = int'($urandom % 8);
            sz = (r == 7) ? 2'b11 : 2'(r % 3);
            addr = $urandom;
            if (sz != 2'b11 && ($urandom % 4) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
            dly = (($urandom % 4) == 0) ? int'($urandom_range(T + 4, T - 2)) : int'($urandom_range(3, 1));
            issue(1'($urandom), sz, addr, $urandom, 1'($urandom), dly, $urandom);
            if (($urandom % 5) == 0) idle(1);
        end
        idle(T + 4);

        // Reset in the middle of an access
        issue(1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 1000, $urandom);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_lw_en", 32'(mem_lw_en), 32'd1);
        rst = 1'b1;
        sq.delete();
        mq.delete();
        @(negedge clk);
        check_reset_state("mid_access_reset");
        rst = 1'b0;
        idle(3);

        // Stray acknowledge while idle
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stray_ack_req_ready",  32'(req_ready),  32'd1);
            check("stray_ack_resp_valid", 32'(resp_valid), 32'd0);
        end
        issue(1'b0, 2'b00, 32'h200, 32'h0, 1'b0, 2, 32'h1234_5678);
        idle(1);

        guard = 0;
        while ((sq.size() != 0 || mq.size() != 0 || mon_active) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_resp_queue", 32'(sq.size()), 32'd0);
        check("drain_mem_queue",  32'(mq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 16, max cycles in ACCESS awaiting mem_ack before abort.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal size.
- mem_addr  out  32  word address {req_addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-placed store data.
- mem_be  out  4  byte enables, bit 3 = bits [31:24].
- mem_lw_en  out  1  load strobe to data memory.
- mem_sw_en  out  1  store strobe to data memory.
- mem_rdata  in  32  word returned by data memory.
- mem_ack  in  1  memory completion.
REQ-003 SHALL use clk as the only clock; rst SHALL be synchronous and active-high.

Function
REQ-004 SHALL be big-endian: byte offset k = addr[1:0] occupies bits [31-8k:24-8k], mem_be bit 3-k; the halfword at offset 0 occupies [31:16], at offset 2 occupies [15:0].
REQ-005 SHALL implement FSM with states IDLE, ACCESS and RESP; all outputs SHALL be registered.
REQ-006 SHALL assert req_ready only in IDLE; a request is accepted at a posedge where req_valid and req_ready are both 1.
REQ-007 On an accepted legal, aligned request, SHALL go to ACCESS next cycle, drive mem_addr, mem_be and mem_wdata, and raise exactly one of mem_lw_en or mem_sw_en.
REQ-008 SHALL hold the mem_* outputs stable throughout ACCESS; on the posedge sampling mem_ack=1, SHALL drop the enables and go to RESP.
REQ-009 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE; minimum latency is accept at edge N, enable during N+1, resp_valid during N+2.
REQ-010 Store data placement SHALL be: byte replicated to all 4 lanes; half replicated to both halves; word unchanged. Only mem_be selects the written lanes.
REQ-011 Loads SHALL extract the addressed lane from mem_rdata and zero- or sign-extend it per req_unsigned; word loads SHALL ignore req_unsigned.
REQ-012 Misalignment (half with addr[0]=1, word with addr[1:0]!=0) or req_size=11 SHALL produce no mem enable; the unit SHALL go straight to RESP with err 01 or 11 (11 takes priority) and resp_rdata=0.
REQ-013 SHALL count cycles in ACCESS; if TIMEOUT_CYCLES elapse without mem_ack, SHALL drop the enables and give RESP with err=10 and rdata=0.
REQ-014 SHALL ignore mem_ack outside ACCESS; an ack arriving in the same cycle as the timeout SHALL win (err=00).
REQ-015 SHALL ignore new requests while busy; the request fields SHALL be latched at acceptance.

Reset
REQ-016 rst=1 at a posedge SHALL force IDLE, with req_ready=1 the following cycle; resp_valid, mem_lw_en, mem_sw_en and mem_be SHALL be 0, and mem_addr, mem_wdata, resp_rdata, resp_err and the timeout counter SHALL be 0.
REQ-017 Reset mid-ACCESS SHALL drop the enables at that edge and produce no response for the aborted request.

Structure
REQ-018 A shared package SHALL hold the size encodings, the resp_err codes, the FSM state enum and the default TIMEOUT_CYCLES.
REQ-019 Lane placement and extraction SHALL live in a single combinational sub-module, lsu_lane_align.

Verification
REQ-020 Store word 0x11223344 at addr 0x40 with ack after 1 cycle -> mem_addr 0x40, be 1111, mem_wdata 0x11223344; resp_valid 2 cycles after accept with err 00.
REQ-021 Load byte at addr 0x43, signed, with mem_rdata 0x000000F0 -> mem_be 0001, resp_rdata 0xFFFFFFF0; the same load unsigned -> 0x000000F0.
REQ-022 Store half 0xABCD at addr 0x42 -> be 0011, mem_wdata 0xABCDABCD; load half at 0x40 with mem_rdata 0x8001xxxx, signed -> 0xFFFF8001.
REQ-023 Load word at addr 0x41 -> no enable, resp_valid the next cycle, err 01; req_size=11 -> err 11.
REQ-024 Ack held low -> mem_lw_en high for 16 cycles, then resp err 10; ack on cycle 16 -> err 00.
REQ-025 Assert rst during ACCESS -> enables 0 the next cycle, no resp_valid, req_ready=1; a stray mem_ack while in IDLE is ignored.
